// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
package rf_arb_pkg;

  localparam int XLEN = 64;
  localparam int NREG = 32;

  // Requester indices, also the encoding of the last-grant pointer
  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_LSU = 1'b1;

  // One queued register write
  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of write-back requests; head is visible combinationally.
module wb_fifo
  import rf_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  wb_req_t wr_req,
  input  logic    pop,
  output wb_req_t head,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  wb_req_t     mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // Pointer update; push and pop are independent and may coincide
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write; contents need no reset since empty masks them
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wr_req;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter for the single register-file write port,
// with per-register pending-write tracking for decode hazard stalls.
module rf_wb_arbiter #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            Wen,
  output logic [4:0]      Rd_addr,
  output logic [XLEN-1:0] write_data,
  output logic [31:0]     pending
);

  import rf_arb_pkg::*;

  // A register can be targeted by every FIFO slot plus the grant stage
  localparam int CNT_MAX = 2 * DEPTH + 1;
  localparam int CW      = $clog2(CNT_MAX + 1);

  function automatic logic [CW-1:0] cnt_step(input logic [CW-1:0] cnt,
                                              input logic inc_a,
                                              input logic inc_b,
                                              input logic dec);
    return cnt + CW'(inc_a) + CW'(inc_b) - CW'(dec);
  endfunction

  wb_req_t alu_req, lsu_req;
  wb_req_t alu_head, lsu_head;
  logic    alu_full, alu_empty, lsu_full, lsu_empty;
  logic    alu_push, lsu_push;
  logic    gnt_alu, gnt_lsu;
  logic    last_grant;
  logic    vld_p0;
  wb_req_t req_p0;

  logic [CW-1:0] cnt     [1:NREG-1];
  logic [CW-1:0] cnt_nxt [1:NREG-1];

  // Ready reflects FIFO space only, so valid never reaches an output
  assign alu_ready = !alu_full && !rst;
  assign lsu_ready = !lsu_full && !rst;

  // x0 writes complete the handshake but are dropped here
  assign alu_push = alu_valid && alu_ready && (alu_rd != 5'd0);
  assign lsu_push = lsu_valid && lsu_ready && (lsu_rd != 5'd0);

  assign alu_req = '{rd: alu_rd, data: alu_data};
  assign lsu_req = '{rd: lsu_rd, data: lsu_data};

  wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (alu_push),
    .wr_req (alu_req),
    .pop    (gnt_alu),
    .head   (alu_head),
    .full   (alu_full),
    .empty  (alu_empty)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_lsu_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (lsu_push),
    .wr_req (lsu_req),
    .pop    (gnt_lsu),
    .head   (lsu_head),
    .full   (lsu_full),
    .empty  (lsu_empty)
  );

  // Round-robin choice between the two FIFO heads
  always_comb begin
    gnt_alu = 1'b0;
    gnt_lsu = 1'b0;
    if (!alu_empty && (lsu_empty || last_grant == REQ_LSU)) gnt_alu = 1'b1;
    else if (!lsu_empty)                                    gnt_lsu = 1'b1;
  end

  // ---- stage p0: granted head popped into the grant register ----
  // Grant-stage control and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0     <= 1'b0;
      last_grant <= REQ_LSU;
    end else begin
      vld_p0 <= gnt_alu || gnt_lsu;
      if (gnt_alu)      last_grant <= REQ_ALU;
      else if (gnt_lsu) last_grant <= REQ_LSU;
    end
  end

  // Grant-stage payload; qualified by vld_p0
  always_ff @(posedge clk) begin
    if (gnt_alu)      req_p0 <= alu_head;
    else if (gnt_lsu) req_p0 <= lsu_head;
  end

  // ---- stage p1: register-file port drive ----
  // Address and data hold their last written values while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      Wen        <= 1'b0;
      Rd_addr    <= '0;
      write_data <= '0;
    end else begin
      Wen <= vld_p0;
      if (vld_p0) begin
        Rd_addr    <= req_p0.rd;
        write_data <= req_p0.data;
      end
    end
  end

  // Pending counters: count up on enqueue, down when the write is driven
  always_comb begin
    for (int i = 1; i < NREG; i++) begin
      cnt_nxt[i] = cnt_step(cnt[i],
                            alu_push && (alu_rd == 5'(i)),
                            lsu_push && (lsu_rd == 5'(i)),
                            vld_p0 && (req_p0.rd == 5'(i)));
    end
  end

  // Pending counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NREG; i++) cnt[i] <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  // Pending mask; x0 never pends
  always_comb begin
    pending = '0;
    for (int i = 1; i < NREG; i++) pending[i] = (cnt[i] != '0);
  end

  // Counters can neither wrap nor underflow
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 1; i < NREG; i++) assert (cnt_nxt[i] <= CW'(CNT_MAX));
    end
  end

endmodule
